result_logger: RTL and testbench
================================

RESULT_LOGGER -- requirements
Module: result_logger

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the result data width.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two), giving the FIFO entry count.
REQ-003 The block SHALL have parameter CAP_CYC, default 4, giving the CYCLE value whose entry triggers a capture.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port OP, input, 2 bits: the operation code driven to the upstream datapath.
REQ-007 The block SHALL have port CYCLE, input, 3 bits: the upstream datapath cycle counter, 1..5.
REQ-008 The block SHALL have port DATA_IN, input, WIDTH bits: the upstream datapath register output.
REQ-009 The block SHALL have port RD_READY, input, 1 bit: the consumer accepts the head entry.
REQ-010 The block SHALL have port CLR_OVF, input, 1 bit: a single-cycle pulse that clears OVERFLOW.
REQ-011 The block SHALL have port RD_VALID, output, 1 bit: the FIFO is non-empty.
REQ-012 The block SHALL have port RD_DATA, output, WIDTH+2 bits: the head entry {op[1:0], result}.
REQ-013 The block SHALL have port COUNT, output, log2(DEPTH)+1 bits: the FIFO occupancy.
REQ-014 The block SHALL have port OVERFLOW, output, 1 bit: a sticky flag marking a dropped capture.

Function
REQ-015 The block SHALL register OP, CYCLE and DATA_IN into an input stage (op_q, cyc_q, data_q) on every CLK edge, and SHALL also keep cyc_prev, the previous value of cyc_q.
REQ-016 A capture event SHALL be asserted when cyc_q == CAP_CYC, cyc_prev != CAP_CYC and op_q != 2'b11.
REQ-017 When OP == 2'b11 (unused opcode), the block SHALL perform no capture, and OVERFLOW SHALL be unaffected.
REQ-018 A capture event SHALL push {op_q, data_q} into the FIFO on the same edge it is detected.
REQ-019 Latency: if CYCLE enters CAP_CYC before edge k, the entry SHALL be pushed at edge k+1 and RD_VALID SHALL be high after edge k+1.
REQ-020 CYCLE held at CAP_CYC over many clocks SHALL cause exactly one push; the next push requires CYCLE to leave CAP_CYC and re-enter it.
REQ-021 The FIFO SHALL be first-word-fall-through: RD_DATA equals the head entry whenever RD_VALID = 1.
REQ-022 RD_DATA SHALL be all-zero when RD_VALID = 0.
REQ-023 A pop SHALL occur on an edge where RD_VALID = 1 and RD_READY = 1; RD_READY while empty SHALL be ignored.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-025 COUNT SHALL change as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 When the FIFO is full, a push with a simultaneous pop SHALL be accepted with no overflow.
REQ-027 When the FIFO is full and a push arrives without a pop, the new entry SHALL be dropped, the FIFO contents SHALL be unchanged, and OVERFLOW SHALL be set.
REQ-028 When the FIFO is empty and a push arrives, RD_VALID SHALL be 0 during that cycle; no same-cycle bypass exists.
REQ-029 OVERFLOW SHALL stay high until a CLR_OVF pulse.
REQ-030 If CLR_OVF and a new overflow occur on the same edge, OVERFLOW SHALL remain 1 (set wins).

Reset
REQ-031 Asserting RESET_N = 0 SHALL immediately clear the pointers, COUNT, OVERFLOW, op_q, data_q, cyc_q and cyc_prev, and SHALL force RD_VALID = 0 and RD_DATA = 0.
REQ-032 FIFO storage contents need not be cleared by reset.
REQ-033 Reset asserted in the middle of an operation SHALL discard all entries.
REQ-034 After RESET_N deasserts, the first capture SHALL require a fresh entry of CYCLE into CAP_CYC; because cyc_q resets to 0, CYCLE already at CAP_CYC counts as an entry.
REQ-035 RESET_N deassertion SHALL be synchronised externally to CLK.

Verification
REQ-036 Single op: OP=1, DATA_IN=8'h32, CYCLE stepping 3->4 -> two edges later RD_VALID=1, RD_DATA=10'b01_00110010, COUNT=1.
REQ-037 Hold: CYCLE held at 4 for 10 clocks with DATA_IN varying -> COUNT=1 throughout.
REQ-038 Fill plus wrap: 5 captures (results 1..5) with RD_READY=0 -> COUNT=4 and OVERFLOW=1; then drain with RD_READY=1 -> reads 1,2,3,4, then RD_VALID=0.
REQ-039 Full with simultaneous push/pop: FIFO holding 4 entries, a capture of 8'hAA while RD_READY=1 -> COUNT stays 4, OVERFLOW stays 0, and 8'hAA is read last.
REQ-040 Unused opcode: OP=3 with CYCLE entering 4 -> no push; separately, CLR_OVF asserted on the same edge as an overflow -> OVERFLOW=1.
REQ-041 Reset mid-stream: 3 entries queued, RESET_N pulsed low -> COUNT=0, RD_VALID=0 and OVERFLOW=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/result_logger.sv
// Captures {op, result} from an upstream datapath when its cycle counter
// enters CAP_CYC, and queues the entries in a first-word-fall-through FIFO.
module result_logger #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int CAP_CYC = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [1:0]               OP,
  input  logic [2:0]               CYCLE,
  input  logic [WIDTH-1:0]         DATA_IN,
  input  logic                     RD_READY,
  input  logic                     CLR_OVF,
  output logic                     RD_VALID,
  output logic [WIDTH+1:0]         RD_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0]    CAP_VAL  = 3'(CAP_CYC);
  localparam logic [CW-1:0] FULL_VAL = CW'(DEPTH);

  logic [1:0]       op_q;
  logic [2:0]       cyc_q;
  logic [2:0]       cyc_prev;
  logic [WIDTH-1:0] data_q;

  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q;

  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q     <= '0;
      cyc_q    <= '0;
      cyc_prev <= '0;
      data_q   <= '0;
    end else begin
      op_q     <= OP;
      cyc_q    <= CYCLE;
      cyc_prev <= cyc_q;
      data_q   <= DATA_IN;
    end
  end

  // Edge-detect on the registered counter so a held CAP_CYC captures once.
  always_comb begin
    capture  = (cyc_q == CAP_VAL) && (cyc_prev != CAP_VAL) && (op_q != 2'b11);
    full     = (count_q == FULL_VAL);
    RD_VALID = (count_q != '0);
    pop      = RD_VALID && RD_READY;
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;
    RD_DATA  = RD_VALID ? mem[rd_ptr] : '0;
    COUNT    = count_q;
    OVERFLOW = ovf_q;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {op_q, data_q};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new drop outranks a clear on the same edge.
      if (drop)         ovf_q <= 1'b1;
      else if (CLR_OVF) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_logger.sv
// Directed bench for result_logger: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_result_logger;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int CAP_CYC = 4;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic [1:0]       OP;
  logic [2:0]       CYCLE;
  logic [WIDTH-1:0] DATA_IN;
  logic             RD_READY;
  logic             CLR_OVF;
  logic             RD_VALID;
  logic [WIDTH+1:0] RD_DATA;
  logic [2:0]       COUNT;
  logic             OVERFLOW;

  int unsigned tests = 0;
  int unsigned fails = 0;

  result_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CAP_CYC(CAP_CYC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .CYCLE(CYCLE), .DATA_IN(DATA_IN),
    .RD_READY(RD_READY), .CLR_OVF(CLR_OVF), .RD_VALID(RD_VALID),
    .RD_DATA(RD_DATA), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the datapath showed at the previous two edges
  // decides whether a new entry arrives; the FIFO itself is a plain queue.
  logic [WIDTH+1:0] mq[$];
  logic             m_ovf;
  logic [2:0]       s1_cyc, s2_cyc;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_data;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mq.delete();
      m_ovf   = 1'b0;
      s1_cyc  = 3'd0;
      s2_cyc  = 3'd0;
      s1_op   = 2'd0;
      s1_data = '0;
    end else begin
      bit enter, do_pop;
      enter  = (s1_cyc == 3'(CAP_CYC)) && (s2_cyc != 3'(CAP_CYC)) && (s1_op != 2'b11);
      do_pop = (mq.size() > 0) && RD_READY;
      if (enter && mq.size() == DEPTH && !do_pop) m_ovf = 1'b1;
      else if (CLR_OVF) m_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (enter && mq.size() < DEPTH) mq.push_back({s1_op, s1_data});
      s2_cyc  = s1_cyc;
      s1_cyc  = CYCLE;
      s1_op   = OP;
      s1_data = DATA_IN;
    end
  end

  always @(negedge CLK) begin
    chk("model_rd_valid", 32'(RD_VALID), 32'(mq.size() > 0));
    chk("model_rd_data",  32'(RD_DATA),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk("model_count",    32'(COUNT),    32'(mq.size()));
    chk("model_overflow", 32'(OVERFLOW), 32'(m_ovf));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One capture: CYCLE 3 -> 4 -> 3; the entry lands on the third edge.
  task automatic cap(input logic [1:0] op, input logic [7:0] d);
    CYCLE = 3'd3; tick();
    CYCLE = 3'd4; OP = op; DATA_IN = d; tick();
    CYCLE = 3'd3; tick();
  endtask

  initial begin
    RESET_N = 1'b0; OP = 2'd0; CYCLE = 3'd1; DATA_IN = '0;
    RD_READY = 1'b0; CLR_OVF = 1'b0;
    #1;
    chk("reset_count", 32'(COUNT), 32'd0);
    chk("reset_valid", 32'(RD_VALID), 32'd0);
    chk("reset_data",  32'(RD_DATA), 32'd0);
    tick(); tick();
    RESET_N = 1'b1;
    tick();

    // Single op with latency
    OP = 2'd1; DATA_IN = 8'h32; CYCLE = 3'd3; tick();
    CYCLE = 3'd4; tick();
    chk("lat_not_yet", 32'(RD_VALID), 32'd0);
    tick();
    chk("single_valid", 32'(RD_VALID), 32'd1);
    chk("single_data",  32'(RD_DATA), 32'h132);
    chk("single_count", 32'(COUNT), 32'd1);

    // Held CAP_CYC
    for (int i = 0; i < 10; i++) begin
      DATA_IN = 8'(i * 7 + 1); tick();
      chk("hold_count", 32'(COUNT), 32'd1);
    end
    RD_READY = 1'b1; CYCLE = 3'd1; tick(); RD_READY = 1'b0;
    chk("hold_drained", 32'(COUNT), 32'd0);

    // Fill plus overflow, then drain
    for (int i = 1; i <= 5; i++) cap(2'd0, 8'(i));
    chk("fill_count", 32'(COUNT), 32'd4);
    chk("fill_ovf",   32'(OVERFLOW), 32'd1);
    RD_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(RD_DATA), 32'(i));
      tick();
    end
    RD_READY = 1'b0;
    chk("drain_empty", 32'(RD_VALID), 32'd0);
    chk("drain_zero",  32'(RD_DATA), 32'd0);
    chk("ovf_sticky",  32'(OVERFLOW), 32'd1);
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    chk("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) cap(2'd2, 8'(8'h10 + i));
    CYCLE = 3'd3; tick();
    CYCLE = 3'd4; OP = 2'd2; DATA_IN = 8'hAA; tick();
    CYCLE = 3'd3; RD_READY = 1'b1; tick();
    RD_READY = 1'b0;
    chk("pp_count", 32'(COUNT), 32'd4);
    chk("pp_ovf",   32'(OVERFLOW), 32'd0);
    RD_READY = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      chk("pp_data", 32'(RD_DATA), 32'(10'h210 + i));
      tick();
    end
    chk("pp_last", 32'(RD_DATA), 32'h2AA);
    tick();
    RD_READY = 1'b0;
    chk("pp_empty", 32'(RD_VALID), 32'd0);

    // Unused opcode
    cap(2'd3, 8'h55);
    chk("op3_nopush", 32'(COUNT), 32'd0);
    for (int i = 1; i <= 4; i++) cap(2'd1, 8'(8'h40 + i));
    cap(2'd3, 8'h56);
    chk("op3_full_noovf", 32'(OVERFLOW), 32'd0);
    chk("op3_full_count", 32'(COUNT), 32'd4);

    // Clear and overflow on the same edge
    CYCLE = 3'd3; tick();
    CYCLE = 3'd4; OP = 2'd1; DATA_IN = 8'h99; tick();
    CYCLE = 3'd3; CLR_OVF = 1'b1; tick();
    CLR_OVF = 1'b0;
    chk("set_wins", 32'(OVERFLOW), 32'd1);
    chk("drop_head", 32'(RD_DATA), 32'h141);

    // Reset mid-stream with 3 entries queued
    RD_READY = 1'b1; tick(); RD_READY = 1'b0;
    chk("pre_reset_count", 32'(COUNT), 32'd3);
    OP = 2'd2; DATA_IN = 8'h77; CYCLE = 3'd4;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_reset_count", 32'(COUNT), 32'd0);
    chk("mid_reset_valid", 32'(RD_VALID), 32'd0);
    chk("mid_reset_ovf",   32'(OVERFLOW), 32'd0);
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    chk("post_reset_wait", 32'(RD_VALID), 32'd0);
    tick();
    chk("post_reset_count", 32'(COUNT), 32'd1);
    chk("post_reset_data",  32'(RD_DATA), 32'h277);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
